// File: rtl/mlp_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mlp_seq_pkg
// Description : Shared state encoding and constants for the MLP layer
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mlp_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_START       = 3'd1,
        S_CIM_WAIT_HI = 3'd2,
        S_CIM_WAIT_LO = 3'd3,
        S_NEXT_WAIT   = 3'd4,
        S_FUNC        = 3'd5,
        S_FUNC_WAIT   = 3'd6
    } seq_state_e;

    // Cycles of FUNC_WAIT during which layer busy has not yet risen.
    localparam int FUNC_BUSY_SKIP = 1;
    localparam int SKIP_W = (FUNC_BUSY_SKIP < 2) ? 1 : $clog2(FUNC_BUSY_SKIP + 1);

    function automatic int wdog_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module      : layer_seq_fsm
// Description : One fc_layer's start/CIM/func sequencing FSM with pulse
//               outputs; optional wait-state watchdog (SEQ_WATCHDOG_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module layer_seq_fsm
    import mlp_seq_pkg::*;
#(
    parameter int WDOG_CYCLES = 65535,
    parameter int WDOG_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start_req,
    input  logic i_cim_busy,
    input  logic i_layer_busy,
    input  logic i_next_busy,
    output logic o_start,
    output logic o_func_start,
    output logic o_done,
    output logic o_active,
    output logic o_error
);

    seq_state_e        r_state;
    logic [SKIP_W-1:0] r_skip_cnt;
    logic              w_skip_done;
    logic              w_timeout;

    assign w_skip_done  = (r_skip_cnt >= SKIP_W'(FUNC_BUSY_SKIP));
    assign o_start      = (r_state == S_START);
    assign o_func_start = (r_state == S_FUNC);
    assign o_active     = (r_state != S_IDLE);
    assign o_done       = (r_state == S_FUNC_WAIT) && w_skip_done && !i_layer_busy && !w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_skip_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE:        if (i_start_req)  r_state <= S_START;
                S_START:       r_state <= S_CIM_WAIT_HI;
                S_CIM_WAIT_HI: if (i_cim_busy)   r_state <= S_CIM_WAIT_LO;
                S_CIM_WAIT_LO: if (!i_cim_busy)  r_state <= S_NEXT_WAIT;
                S_NEXT_WAIT:   if (!i_next_busy) r_state <= S_FUNC;
                S_FUNC: begin
                    r_state    <= S_FUNC_WAIT;
                    r_skip_cnt <= '0;
                end
                S_FUNC_WAIT: begin
                    if (o_done)
                        r_state <= S_IDLE;
                    else if (!w_skip_done)
                        r_skip_cnt <= r_skip_cnt + SKIP_W'(1);
                end
                default:       r_state <= S_IDLE;
            endcase
            // An expired watchdog abandons the layer without a done pulse.
            if (w_timeout)
                r_state <= S_IDLE;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    logic [WDOG_W-1:0] r_wdog;
    logic              r_error;
    logic              w_in_wait;
    logic              w_leave;

    assign w_in_wait = (r_state == S_CIM_WAIT_HI) || (r_state == S_CIM_WAIT_LO)
                    || (r_state == S_FUNC_WAIT);
    // Any exit from the current wait state restarts the count for the next one.
    assign w_leave   = ((r_state == S_CIM_WAIT_HI) && i_cim_busy)
                    || ((r_state == S_CIM_WAIT_LO) && !i_cim_busy)
                    || ((r_state == S_FUNC_WAIT) && o_done);
    assign w_timeout = w_in_wait && (r_wdog == WDOG_W'(WDOG_CYCLES));
    assign o_error   = r_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog  <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_timeout)
                r_error <= 1'b1;
            if (!w_in_wait || w_leave || w_timeout)
                r_wdog <= '0;
            else
                r_wdog <= r_wdog + WDOG_W'(1);
        end
    end
`else
    logic [WDOG_W-1:0] w_unused_wdog;

    assign w_unused_wdog = WDOG_W'(WDOG_CYCLES);
    assign w_timeout     = 1'b0;
    assign o_error       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/mlp_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mlp_layer_sequencer
// Description : Schedules a pipelined chain of fc_layer stages: frame
//               handshake, done chaining and downstream back-pressure.
//               Optional watchdog enabled by SEQ_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_layer_sequencer
    import mlp_seq_pkg::*;
#(
    parameter int N_LAYERS    = 5,
    parameter int WDOG_CYCLES = 65535,
    parameter int WDOG_W      = wdog_width(WDOG_CYCLES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_frame_valid,
    output logic                o_frame_ready,
    output logic                o_frame_done,
    input  logic                i_sink_busy,
    output logic [N_LAYERS-1:0] o_start,
    output logic [N_LAYERS-1:0] o_func_start,
    input  logic [N_LAYERS-1:0] i_cim_busy,
    input  logic [N_LAYERS-1:0] i_layer_busy,
    output logic [N_LAYERS-1:0] o_next_busy,
    output logic [N_LAYERS-1:0] o_active,
    output logic [N_LAYERS-1:0] o_error
);

    logic [N_LAYERS-1:0] w_done;
    logic [N_LAYERS-1:0] w_start_req;

    assign o_frame_ready = !o_active[0];
    assign o_frame_done  = w_done[N_LAYERS-1];

    generate
        for (genvar k = 0; k < N_LAYERS; k++) begin : g_layer
            if (k == 0) begin : g_head
                assign w_start_req[k] = i_frame_valid && o_frame_ready;
            end else begin : g_chain
                // Safe: layer k+1 is IDLE whenever layer k can finish.
                assign w_start_req[k] = w_done[k-1];
            end

            if (k == N_LAYERS - 1) begin : g_tail
                assign o_next_busy[k] = i_sink_busy;
            end else begin : g_mid
                assign o_next_busy[k] = o_active[k+1];
            end

            layer_seq_fsm #(
                .WDOG_CYCLES (WDOG_CYCLES),
                .WDOG_W      (WDOG_W)
            ) u_fsm (
                .clk          (clk),
                .rst          (rst),
                .i_start_req  (w_start_req[k]),
                .i_cim_busy   (i_cim_busy[k]),
                .i_layer_busy (i_layer_busy[k]),
                .i_next_busy  (o_next_busy[k]),
                .o_start      (o_start[k]),
                .o_func_start (o_func_start[k]),
                .o_done       (w_done[k]),
                .o_active     (o_active[k]),
                .o_error      (o_error[k])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/mlp_layer_sequencer.md
Name: mlp_layer_sequencer

Overview:
- Central scheduler for a chain of N_LAYERS fc_layer instances in a crossbar-CIM MLP top.
- Per layer, generates the start pulse for the CIM phase and the func-start pulse for the activation/write-out phase.
- Tracks each layer's busy signals and provides the downstream-busy back-pressure for each layer.
- Pipelines frames: layer k may process frame n+1 while layer k+1 processes frame n.

Parameters:
- N_LAYERS, 5, number of fc_layer stages sequenced (>=1).
- WDOG_CYCLES, 65535, watchdog limit per wait state; used only with SEQ_WATCHDOG_EN.
- WDOG_W, $clog2(WDOG_CYCLES+1), watchdog counter width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_frame_valid  in  1  a new input frame is fully loaded into layer 0's ibuf
- o_frame_ready  out  1  layer 0 can accept a frame (its FSM is IDLE)
- o_frame_done  out  1  one-cycle pulse when the last layer completes its func phase
- i_sink_busy  in  1  consumer of the last layer's output is busy
- o_start  out  N_LAYERS  per-layer one-cycle start pulse; drives fc_layer i_start
- o_func_start  out  N_LAYERS  per-layer one-cycle func-start pulse; drives fc_layer i_func_start
- i_cim_busy  in  N_LAYERS  per-layer crossbar busy
- i_layer_busy  in  N_LAYERS  per-layer fc_layer o_busy
- o_next_busy  out  N_LAYERS  per-layer downstream busy; drives fc_layer i_next_busy
- o_active  out  N_LAYERS  per-layer FSM not IDLE
- o_error  out  N_LAYERS  sticky watchdog error; constant 0 without SEQ_WATCHDOG_EN

Behaviour:
- Clocking: single clock; synchronous active-high reset.
- Reset: all FSMs go to IDLE. o_start, o_func_start, o_frame_done, o_active and o_error are 0. o_frame_ready is 1.
- A rst asserted mid-operation aborts all layers immediately. No pulses are issued in the cycle after rst.
- Per-layer FSM states: IDLE, START, CIM_WAIT_HI, CIM_WAIT_LO, NEXT_WAIT, FUNC, FUNC_WAIT.
- Start request per layer:
  - Layer 0: i_frame_valid && o_frame_ready.
  - Layer k>0: the done pulse of layer k-1.
- IDLE -> START on a start request. START is one cycle: o_start[k]=1, then -> CIM_WAIT_HI.
- CIM_WAIT_HI -> CIM_WAIT_LO when i_cim_busy[k]=1.
- CIM_WAIT_LO -> NEXT_WAIT when i_cim_busy[k]=0.
- NEXT_WAIT -> FUNC when o_next_busy[k]=0.
- FUNC is one cycle: o_func_start[k]=1, then -> FUNC_WAIT.
- FUNC_WAIT: the first cycle is ignored (busy-rise latency). From the second cycle on, i_layer_busy[k]=0 -> IDLE and emits layer k's done pulse.
- Downstream busy:
  - o_next_busy[k] = (FSM[k+1] != IDLE) for k < N_LAYERS-1.
  - o_next_busy[N_LAYERS-1] = i_sink_busy.
  - Combinational from state regs and i_sink_busy.
- Layer k+1 enters START the cycle after layer k's done pulse. Layer k+1 is guaranteed IDLE then, because layer k waited in NEXT_WAIT.
- o_frame_done is the done pulse of layer N_LAYERS-1. It is a registered-state decode, coincident with that FSM's FUNC_WAIT->IDLE transition edge; it is high in the cycle the FSM is last in FUNC_WAIT with busy=0.
- Latency, uncongested: frame accept -> o_start[0] high in the next cycle. Layer k done -> o_start[k+1] in the next cycle.
- Simultaneous events:
  - i_frame_valid while layer 0 is not IDLE: frame not accepted; source holds i_frame_valid.
  - Layer k done in the same cycle layer k+1 leaves IDLE: cannot occur by construction. The verifier asserts this.
- At most one of o_start[k], o_func_start[k] is high per cycle per layer. Pulses never exceed one cycle.
- N_LAYERS=1: layer 0 uses i_sink_busy directly.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- With the macro defined:
  - Each layer has a WDOG_W-bit counter, cleared on entry to any wait state and incremented while in CIM_WAIT_HI, CIM_WAIT_LO or FUNC_WAIT.
  - When the count reaches WDOG_CYCLES, o_error[k] is set sticky and FSM[k] is forced to IDLE with no done pulse.
  - o_error is cleared only by rst.
- Without the macro: no counters; o_error is tied to 0; wait states wait indefinitely.

Decomposition:
- Package mlp_seq_pkg:
  - seq_state_e enum of the 7 states;
  - localparam FUNC_BUSY_SKIP = 1;
  - function for the watchdog width.
- Sub-module layer_seq_fsm holds one layer's FSM, watchdog and pulse outputs. It is instantiated N_LAYERS times in a generate loop. The top handles the done/next_busy chaining and the frame handshake.

Test Plan:
- Reset: assert rst for 3 cycles mid-operation (layer 1 in CIM_WAIT_LO) -> next cycle all outputs 0 except o_frame_ready=1; no pulses.
- Single frame, N_LAYERS=5, each cim_busy high 4 cycles, layer_busy high 3 cycles, sink idle -> o_start[0..4] and o_func_start[0..4] each pulse exactly once, in order; exactly one o_frame_done.
- Back-pressure: i_sink_busy=1 for 50 cycles -> layer 4 holds in NEXT_WAIT, o_func_start[4]=0; after release, o_func_start[4] fires within 1 cycle.
- Pipelining: two frames back-to-back -> o_frame_ready drops on accept, rises when layer 0 returns to IDLE; second o_start[0] occurs while layer 1 is active; two o_frame_done pulses.
- Stall: frame offered while layer 0 is busy -> no o_start[0] until IDLE; held i_frame_valid then accepted with no duplicate start.
- SEQ_WATCHDOG_EN, WDOG_CYCLES=16: i_cim_busy[2] stuck high -> o_error[2]=1 after 16 cycles; layer 2 returns to IDLE; no o_frame_done; o_error stays 1 until rst.
